// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: byte-serial big-endian instruction fetch, memory-port
// ownership between fetch and execute, PC update at retire, and halt on faults.
module exec_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000,
    parameter int          DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [31:0]           o_mem_addr,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic [31:0]           o_inst,
    output logic [31:0]           o_pc,
    input  logic [31:0]           i_exe_mem_addr,
    input  logic                  i_exe_mem_write,
    input  logic [DATA_WIDTH-1:0] i_exe_mem_data,
    output logic [DATA_WIDTH-1:0] o_exe_mem_data,
    input  logic                  i_exe_ready,
    input  logic                  i_exe_pc_change,
    input  logic [31:0]           i_exe_new_pc,
    input  logic                  i_exe_invalid_inst,
    output logic                  o_halted,
    output logic [1:0]            o_halt_cause,
    output logic [31:0]           o_retired
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [1:0] CAUSE_INVALID    = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] retired_q, retired_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  cause_q, cause_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            retired_q <= '0;
            k_q       <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
            k_q       <= k_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_d         = inst_q;
        retired_d      = retired_q;
        k_d            = k_q;
        cause_d        = cause_q;
        o_mem_addr     = '0;
        o_mem_write    = 1'b0;
        o_mem_data     = '0;
        o_exe_mem_data = '0;
        o_inst         = NOP_INST;

        case (state_q)
            S_FETCH: begin
                o_mem_addr = pc_q + {30'd0, k_q};
                // Lowest address is the most significant byte.
                inst_d[5'd31 - {k_q, 3'b000} -: 8] = i_mem_data;
                k_d = k_q + 2'd1;
                if (k_q == 2'd3)
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                o_inst         = inst_q;
                o_mem_addr     = i_exe_mem_addr;
                o_mem_write    = i_exe_mem_write;
                o_mem_data     = i_exe_mem_data;
                o_exe_mem_data = i_mem_data;
                if (i_exe_invalid_inst) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_INVALID;
                end else if (i_exe_ready && i_exe_pc_change && (i_exe_new_pc[1:0] != 2'b00)) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_MISALIGNED;
                end else if (i_exe_ready) begin
                    pc_d      = i_exe_pc_change ? i_exe_new_pc : pc_q + 32'd4;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end
            S_HALT: begin
                // Parked: port idle, only reset leaves this state.
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign o_pc         = pc_q;
    assign o_halted     = (state_q == S_HALT);
    assign o_halt_cause = cause_q;
    assign o_retired    = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized self-checking bench for exec_sequencer; expectations come from a
// per-instruction model of fetch/execute/retire rules kept in the bench.
module tb_exec_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_mem_data;
    logic [31:0] o_mem_addr;
    logic        o_mem_write;
    logic [7:0]  o_mem_data;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] i_exe_mem_addr = '0;
    logic        i_exe_mem_write = 1'b0;
    logic [7:0]  i_exe_mem_data = '0;
    logic [7:0]  o_exe_mem_data;
    logic        i_exe_ready = 1'b0;
    logic        i_exe_pc_change = 1'b0;
    logic [31:0] i_exe_new_pc = '0;
    logic        i_exe_invalid_inst = 1'b0;
    logic        o_halted;
    logic [1:0]  o_halt_cause;
    logic [31:0] o_retired;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference architectural state
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [1:0]  m_cause;

    exec_sequencer #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST), .DATA_WIDTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_mem_data(i_mem_data),
        .o_mem_addr(o_mem_addr), .o_mem_write(o_mem_write), .o_mem_data(o_mem_data),
        .o_inst(o_inst), .o_pc(o_pc),
        .i_exe_mem_addr(i_exe_mem_addr), .i_exe_mem_write(i_exe_mem_write),
        .i_exe_mem_data(i_exe_mem_data), .o_exe_mem_data(o_exe_mem_data),
        .i_exe_ready(i_exe_ready), .i_exe_pc_change(i_exe_pc_change),
        .i_exe_new_pc(i_exe_new_pc), .i_exe_invalid_inst(i_exe_invalid_inst),
        .o_halted(o_halted), .o_halt_cause(o_halt_cause), .o_retired(o_retired)
    );

    always #5 i_clk = ~i_clk;

    // Memory image: ADDI x1,x0,10 at address 0, address-hashed bytes elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h00;
            32'd1:   return 8'hA0;
            32'd2:   return 8'h00;
            32'd3:   return 8'h93;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5C;
        endcase
    endfunction

    assign i_mem_data = mem_byte(o_mem_addr);

    task automatic drive_exe_rand();
        i_exe_mem_addr     = $urandom;
        i_exe_mem_write    = 1'($urandom);
        i_exe_mem_data     = 8'($urandom);
        i_exe_ready        = 1'($urandom);
        i_exe_pc_change    = 1'($urandom);
        i_exe_new_pc       = $urandom;
        i_exe_invalid_inst = 1'($urandom);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        drive_exe_rand();
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        m_pc = RESET_PC; m_ret = 0; m_cause = 2'b00;
    endtask

    // Fetch nbytes bytes; exe inputs are random noise that must be ignored.
    task automatic do_fetch(input int nbytes, output logic [31:0] word);
        word = '0;
        for (int k = 0; k < nbytes; k++) begin
            @(negedge i_clk);
            drive_exe_rand();
            i_exe_mem_write = 1'b1;
            #1;
            n_checks++;
            if (o_mem_addr !== m_pc + k) begin
                n_fail++; $display("FAIL fetch_addr k=%0d got %h exp %h", k, o_mem_addr, m_pc + k);
            end
            n_checks++;
            if ({o_mem_write, o_mem_data, o_exe_mem_data, o_inst} !== {1'b0, 8'h00, 8'h00, NOP_INST}) begin
                n_fail++; $display("FAIL fetch_port got w=%b d=%h r=%h inst=%h exp 0/00/00/%h",
                                   o_mem_write, o_mem_data, o_exe_mem_data, o_inst, NOP_INST);
            end
            n_checks++;
            if ({o_pc, o_retired, o_halted, o_halt_cause} !== {m_pc, m_ret, 1'b0, 2'b00}) begin
                n_fail++; $display("FAIL fetch_state got pc=%h ret=%0d h=%b c=%b exp pc=%h ret=%0d h=0 c=00",
                                   o_pc, o_retired, o_halted, o_halt_cause, m_pc, m_ret);
            end
            word = {word[23:0], mem_byte(m_pc + k)};
        end
    endtask

    // Execute for ncyc cycles; the final cycle ends it per kind:
    // 0 = retire, 1 = invalid, 2 = jump (tgt). abort_at >= 0 asserts reset on that cycle.
    task automatic do_exec(input logic [31:0] word, input int ncyc, input int kind,
                           input logic [31:0] tgt, input int abort_at);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge i_clk);
            drive_exe_rand();
            i_exe_ready = 1'b0;
            i_exe_invalid_inst = 1'b0;
            if (c == abort_at) begin
                i_rst = 1'b1;
                i_exe_mem_write = 1'b1;
            end else if (c == ncyc - 1) begin
                i_exe_ready     = (kind == 1) ? 1'($urandom) : 1'b1;
                i_exe_invalid_inst = (kind == 1);
                i_exe_pc_change = (kind == 2) ? 1'b1 : (kind == 1) ? 1'($urandom) : 1'b0;
                if (kind == 2) i_exe_new_pc = tgt;
            end
            #1;
            n_checks++;
            if ({o_mem_addr, o_mem_write, o_mem_data, o_exe_mem_data} !==
                {i_exe_mem_addr, i_exe_mem_write, i_exe_mem_data, mem_byte(i_exe_mem_addr)}) begin
                n_fail++; $display("FAIL exec_passthru got a=%h w=%b d=%h r=%h exp a=%h w=%b d=%h r=%h",
                                   o_mem_addr, o_mem_write, o_mem_data, o_exe_mem_data,
                                   i_exe_mem_addr, i_exe_mem_write, i_exe_mem_data, mem_byte(i_exe_mem_addr));
            end
            n_checks++;
            if ({o_inst, o_pc, o_retired, o_halted} !== {word, m_pc, m_ret, 1'b0}) begin
                n_fail++; $display("FAIL exec_state got inst=%h pc=%h ret=%0d h=%b exp inst=%h pc=%h ret=%0d h=0",
                                   o_inst, o_pc, o_retired, o_halted, word, m_pc, m_ret);
            end
            if (c == abort_at) begin
                @(posedge i_clk);
                #1 i_rst = 1'b0;
                m_pc = RESET_PC; m_ret = 0; m_cause = 2'b00;
                return;
            end
        end
        if (kind == 1)                      m_cause = 2'b01;
        else if (kind == 2 && tgt[1:0] != 0) m_cause = 2'b10;
        else begin
            m_pc  = (kind == 2) ? tgt : m_pc + 32'd4;
            m_ret = m_ret + 1;
        end
    endtask

    task automatic check_halt(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            drive_exe_rand();
            i_exe_mem_write = 1'b1;
            #1;
            n_checks++;
            if ({o_halted, o_halt_cause, o_pc, o_retired} !== {1'b1, m_cause, m_pc, m_ret}) begin
                n_fail++; $display("FAIL halt_state got h=%b c=%b pc=%h ret=%0d exp h=1 c=%b pc=%h ret=%0d",
                                   o_halted, o_halt_cause, o_pc, o_retired, m_cause, m_pc, m_ret);
            end
            n_checks++;
            if ({o_mem_addr, o_mem_write, o_mem_data, o_exe_mem_data, o_inst} !==
                {32'h0, 1'b0, 8'h00, 8'h00, NOP_INST}) begin
                n_fail++; $display("FAIL halt_port got a=%h w=%b d=%h r=%h inst=%h exp all zero/NOP",
                                   o_mem_addr, o_mem_write, o_mem_data, o_exe_mem_data, o_inst);
            end
        end
    endtask

    task automatic test_reset_and_addi();
        logic [31:0] w;
        do_reset();
        do_fetch(4, w);
        n_checks++;
        if (w !== 32'h00A0_0093) begin
            n_fail++; $display("FAIL addi_word got %h exp 00a00093", w);
        end
        do_exec(w, 1, 0, 0, -1);
    endtask

    task automatic test_lw();
        logic [31:0] w;
        do_fetch(4, w); do_exec(w, 1, 0, 0, -1);   // pc 4
        do_fetch(4, w); do_exec(w, 4, 0, 0, -1);   // LW at pc 8
        n_checks++;
        if (m_pc !== 32'd12 || m_ret !== 32'd3) begin
            n_fail++; $display("FAIL lw_model got pc=%h ret=%0d exp 0000000c/3", m_pc, m_ret);
        end
    endtask

    task automatic test_jal_and_invalid();
        logic [31:0] w;
        do_fetch(4, w); do_exec(w, 1, 0, 0, -1);          // pc 12
        do_fetch(4, w); do_exec(w, 1, 2, 32'h40, -1);     // JAL at 16
        do_fetch(4, w); do_exec(w, 2, 2, 32'h14, -1);     // back to 20
        do_fetch(4, w); do_exec(w, 3, 1, 0, -1);          // invalid at 20
        check_halt(12);
    endtask

    task automatic test_misaligned();
        logic [31:0] w;
        do_reset();
        do_fetch(4, w); do_exec(w, 1, 2, 32'h42, -1);
        check_halt(5);
        do_reset();
        do_fetch(4, w);
        do_exec(w, 1, 0, 0, -1);
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] w;
        do_fetch(2, w);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_mem_addr !== m_pc + 2) begin
            n_fail++; $display("FAIL midfetch_addr got %h exp %h", o_mem_addr, m_pc + 2);
        end
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        m_pc = RESET_PC; m_ret = 0; m_cause = 2'b00;
        do_fetch(4, w);
        do_exec(w, 2, 0, 0, -1);
    endtask

    task automatic test_reset_mid_exec();
        logic [31:0] w;
        do_fetch(4, w);
        do_exec(w, 4, 0, 0, 1);
        do_fetch(4, w);
        do_exec(w, 1, 0, 0, -1);
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        do_fetch(4, w); do_exec(w, 1, 2, 32'hFFFF_FFFC, -1);
        do_fetch(4, w); do_exec(w, 1, 0, 0, -1);
        n_checks++;
        if (m_pc !== 32'h0) begin
            n_fail++; $display("FAIL wrap_model got %h exp 0", m_pc);
        end
        do_fetch(4, w); do_exec(w, 1, 0, 0, -1);
    endtask

    task automatic test_random();
        logic [31:0] w;
        int ncyc, kind;
        logic [31:0] tgt;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       ncyc = 1;
                1:       ncyc = 2;
                default: ncyc = 4;
            endcase
            kind = ($urandom_range(0, 3) == 0) ? 2 : 0;
            tgt  = $urandom & 32'hFFFF_FFFC;
            do_fetch(4, w);
            do_exec(w, ncyc, kind, tgt, -1);
        end
        do_fetch(4, w);
        do_exec(w, 2, 2, ($urandom & 32'hFFFF_FFFC) | 32'h1, -1);
        check_halt(4);
    endtask

    initial begin
        test_reset_and_addi();
        test_lw();
        test_jal_and_invalid();
        test_misaligned();
        test_reset_mid_fetch();
        test_reset_mid_exec();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Control unit that sequences the execute stage.
- Fetches each 32-bit instruction over the shared byte-wide memory port and presents it to execute, together with the PC.
- Owns the port arbitration: the port belongs to fetch while fetching and to execute while an instruction runs.
- Applies execute's PC change, or advances by 4, at instruction retire. Halts on an invalid instruction or a misaligned target.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- NOP_INST, 32'h0000_0000, word presented to execute while fetching or halted. It must decode as the custom NOP opcode.
- DATA_WIDTH, 8, memory port width. Only 8 is supported.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_mem_data  in  8  read byte from memory (combinational, valid in the same cycle as o_mem_addr)
- o_mem_addr  out  32  memory address
- o_mem_write  out  1  memory write strobe
- o_mem_data  out  8  memory write byte
- o_inst  out  32  instruction to execute
- o_pc  out  32  PC of o_inst
- i_exe_mem_addr  in  32  execute memory address
- i_exe_mem_write  in  1  execute write strobe
- i_exe_mem_data  in  8  execute write byte
- o_exe_mem_data  out  8  read byte returned to execute
- i_exe_ready  in  1  execute is in the last cycle of the current instruction
- i_exe_pc_change  in  1  execute requests a jump
- i_exe_new_pc  in  32  jump target
- i_exe_invalid_inst  in  1  execute decoded an illegal instruction
- o_halted  out  1  core halted
- o_halt_cause  out  2  01 = invalid instruction, 10 = misaligned target, 00 = running
- o_retired  out  32  count of retired instructions

Behaviour:
- The i_rst reset is synchronous and active-high on the i_clk clock. Reset has priority over everything else, including mid-fetch and mid-execute.
- Reset state:
  - state = FETCH, pc = RESET_PC, byte index k = 0.
  - Instruction register = NOP_INST, o_retired = 0, o_halted = 0, o_halt_cause = 00.
- Every state, exactly one source drives the memory port; the mux is combinational on state.
- FETCH (k = 0..3):
  - o_mem_addr = pc + k, o_mem_write = 0, o_mem_data = 0, o_exe_mem_data = 0.
  - o_inst = NOP_INST, so execute performs no architectural action.
  - Each edge latches i_mem_data into inst[31-8k -: 8]. The byte at the lowest address lands in inst[31:24] (big-endian, matching execute's load byte order).
  - k increments each edge. At k = 3 the edge completes the word, sets k = 0 and moves to EXEC.
  - Fetch therefore takes exactly 4 cycles.
- EXEC:
  - o_inst = latched instruction, o_pc = pc.
  - Memory port is pass-through from the i_exe_* signals. o_exe_mem_data = i_mem_data.
  - At each edge, evaluate in priority order:
    1. i_exe_invalid_inst = 1: go to HALT with cause 01. pc unchanged, no retire.
    2. i_exe_ready = 1 and i_exe_pc_change = 1 and i_exe_new_pc[1:0] != 0: go to HALT with cause 10. pc unchanged, no retire.
    3. i_exe_ready = 1: pc = i_exe_new_pc if i_exe_pc_change, else pc + 4 (mod 2^32). o_retired += 1 (wraps). Go to FETCH.
    4. Otherwise stay in EXEC; multi-cycle loads and stores hold the port.
- HALT:
  - o_inst = NOP_INST, o_mem_write = 0, o_mem_addr = 0, o_mem_data = 0, o_exe_mem_data = 0.
  - o_halted = 1, o_halt_cause held, o_pc holds the faulting PC.
  - Only reset exits HALT.
- i_exe_pc_change and i_exe_new_pc are sampled only on an edge where i_exe_ready = 1 in EXEC.
- Instruction latency = 4 fetch cycles + the execute cycles (1 for ALU/branch/jump, 2 for LH/SH, 4 for LW/SW).
- pc + 4 at 32'hFFFF_FFFC wraps to 0 with no fault.

Test Plan:
- Reset, memory bytes 0..3 = 00 A0 00 93 (ADDI x1,x0,10): o_mem_addr = 0,1,2,3 on cycles 1-4 with o_inst = NOP_INST; cycle 5 o_inst = 32'h00A00093, o_pc = 0; next edge pc = 4, o_retired = 1.
- LW at pc 8 with execute holding i_exe_ready low for 3 cycles: o_mem_addr follows i_exe_mem_addr for all 4 cycles, o_exe_mem_data = i_mem_data; retire only on the 4th edge; pc = 12.
- JAL at pc 16 with i_exe_pc_change = 1 and i_exe_new_pc = 32'h40: next fetch addresses are 40, 41, 42, 43; o_retired increments.
- i_exe_invalid_inst = 1 at pc 20: o_halted = 1, o_halt_cause = 01, o_pc = 20, o_mem_write = 0 and o_retired unchanged for 10+ cycles.
- Jump to 32'h42: HALT with cause 10 and no retire. Pulse i_rst for one cycle: pc = RESET_PC, fetch restarts at k = 0, o_retired = 0.
- Assert i_rst during fetch byte k = 2 and separately during LW cycle 2: o_mem_write = 0 on the next cycle and fetch restarts at RESET_PC.
